// File: rtl/system_pkg.sv
// Shared types for the bus cycle monitor: instruction-cycle phase encoding,
// the fetch record layout and the two-word opcode decode.
package system_pkg;

    // Eight clock phases of one instruction cycle, in bus order
    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    // Phase tracker state
    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_LOCKED = 1'b1
    } mon_state_e;

    // One assembled fetch: 12-bit address, instruction nibbles, second-word flag
    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic        second;
    } fetch_record_t;

    localparam fetch_record_t REC_ZERO = '{addr: 12'h000, opr: 4'h0, opa: 4'h0, second: 1'b0};

    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;

    // True when the opcode is followed by a second instruction word.
    // FIM and SRC share opr=2; only the even opa form (FIM) is two-word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic opa_lsb);
        logic result;
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: result = 1'b1;
            OPR_FIM: result = ~opa_lsb;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Record FIFO with a registered head stage. Capacity counts the head
// register plus the backing storage, so DEPTH records can be held in total.
// DEPTH must be a power of two, at least 2.
module fetch_fifo
    import system_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fetch_record_t push_data,
    input  logic          pop,
    output logic          head_valid,
    output fetch_record_t head_data,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_record_t mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] mem_count_r;
    logic          head_valid_r;
    fetch_record_t head_data_r;

    logic [CW-1:0] total_s;
    logic          pop_s;
    logic          full_s;
    logic          load_s;
    logic          accept_s;
    logic          drop_s;

    // Occupancy and handshake decode; a pop frees room for a same-cycle push
    always_comb begin
        total_s  = mem_count_r + {{(CW-1){1'b0}}, head_valid_r};
        pop_s    = head_valid_r & pop;
        full_s   = (total_s == CW'(DEPTH));
        load_s   = (mem_count_r != {CW{1'b0}}) && (!head_valid_r || pop_s);
        accept_s = push && (!full_s || pop_s);
        drop_s   = push && full_s && !pop_s;
    end

    // Backing storage, written on every accepted push
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and the registered head
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            mem_count_r  <= {CW{1'b0}};
            head_valid_r <= 1'b0;
            head_data_r  <= REC_ZERO;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            mem_count_r <= mem_count_r + CW'(accept_s) - CW'(load_s);
            if (load_s) begin
                head_valid_r <= 1'b1;
                head_data_r  <= mem_r[rd_ptr_r];
            end else if (pop_s) begin
                head_valid_r <= 1'b0;
            end
        end
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;
    assign full       = full_s;
    assign empty      = (total_s == {CW{1'b0}});
    assign drop       = drop_s;

endmodule

// File: rtl/bus_cycle_monitor.sv
// Passive monitor of the 4-bit CPU bus: follows the 8-phase cycle from sync,
// assembles address/instruction nibbles and emits one fetch record per cycle.
// Build option MONITOR_FIFO_EN: buffer records in a FIFO_DEPTH-entry FIFO
// with valid/ready handshake and sticky overflow; otherwise a single output
// register pulses rec_valid during X1.
module bus_cycle_monitor
    import system_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sync,
    input  logic [3:0]  data,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [11:0] rec_addr,
    output logic [3:0]  rec_opr,
    output logic [3:0]  rec_opa,
    output logic        rec_second,
    output logic        desync,
    output logic        overflow
);

    mon_state_e    state_r;
    phase_e        phase_r;
    logic          desync_r;
    logic          second_r;
    logic [11:0]   addr_r;
    logic [3:0]    opr_r;

    logic          publish_s;
    fetch_record_t record_s;
    fetch_record_t out_rec_s;
    logic          out_valid_s;
    logic          overflow_s;

    // The record completes on the edge ending M2 unless sync aborts the cycle
    always_comb begin
        publish_s = (state_r == ST_LOCKED) && (phase_r == PH_M2) && !sync;
        record_s  = '{addr: addr_r, opr: opr_r, opa: data, second: second_r};
    end

    // Phase tracker, nibble capture, desync pulse and second-word flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_UNSYNC;
            phase_r  <= PH_A1;
            desync_r <= 1'b0;
            second_r <= 1'b0;
            addr_r   <= 12'h000;
            opr_r    <= 4'h0;
        end else begin
            case (state_r)
                ST_UNSYNC: begin
                    phase_r  <= PH_A1;
                    desync_r <= 1'b0;
                    second_r <= 1'b0;
                    if (sync) begin
                        state_r <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // sync always realigns; only outside X3 is it a violation
                        phase_r <= PH_A1;
                        if (phase_r != PH_X3) begin
                            desync_r <= 1'b1;
                            second_r <= 1'b0;
                        end else begin
                            desync_r <= 1'b0;
                        end
                    end else if (phase_r == PH_X3) begin
                        state_r  <= ST_UNSYNC;
                        phase_r  <= PH_A1;
                        desync_r <= 1'b1;
                        second_r <= 1'b0;
                    end else begin
                        phase_r  <= phase_e'(phase_r + 3'd1);
                        desync_r <= 1'b0;
                        if (publish_s) begin
                            second_r <= !second_r && is_two_word(opr_r, data[0]);
                        end
                        case (phase_r)
                            PH_A1:   addr_r[3:0]  <= data;
                            PH_A2:   addr_r[7:4]  <= data;
                            PH_A3:   addr_r[11:8] <= data;
                            PH_M1:   opr_r        <= data;
                            default: opr_r        <= opr_r;
                        endcase
                    end
                end
                default: begin
                    state_r  <= ST_UNSYNC;
                    phase_r  <= PH_A1;
                    desync_r <= 1'b0;
                    second_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MONITOR_FIFO_EN
    logic drop_s;
    logic overflow_r;
    logic fifo_full_unused_s;
    logic fifo_empty_unused_s;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (publish_s),
        .push_data  (record_s),
        .pop        (rec_ready),
        .head_valid (out_valid_s),
        .head_data  (out_rec_s),
        .full       (fifo_full_unused_s),
        .empty      (fifo_empty_unused_s),
        .drop       (drop_s)
    );

    // Sticky flag: a record was lost to a full FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow_s = overflow_r;
`else
    fetch_record_t out_rec_r;
    logic          out_valid_r;
    logic          unused_s;

    // Single output register; rec_valid pulses for the one clock of X1
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_rec_r   <= REC_ZERO;
        end else begin
            out_valid_r <= publish_s;
            if (publish_s) begin
                out_rec_r <= record_s;
            end
        end
    end

    assign out_valid_s = out_valid_r;
    assign out_rec_s   = out_rec_r;
    assign overflow_s  = 1'b0;
    assign unused_s    = rec_ready ^ (FIFO_DEPTH == 0);
`endif

    assign phase      = phase_r;
    assign locked     = (state_r == ST_LOCKED);
    assign desync     = desync_r;
    assign rec_valid  = out_valid_s;
    assign rec_addr   = out_rec_s.addr;
    assign rec_opr    = out_rec_s.opr;
    assign rec_opa    = out_rec_s.opa;
    assign rec_second = out_rec_s.second;
    assign overflow   = overflow_s;

endmodule

// File: tb/tb_bus_cycle_monitor.sv
// Directed bench for bus_cycle_monitor: table of fetches with hand-computed
// records, plus sequences for desync, backpressure and mid-cycle reset.
module tb_bus_cycle_monitor;

`ifdef MONITOR_FIFO_EN
    localparam int   VPH    = 6;     // record visible in X2 behind the head register
    localparam logic CHK_BP = 1'b0;  // record not consumed while rec_ready=0
    localparam logic EXP_Q  = 1'b1;  // queued record / sticky overflow expected
`else
    localparam int   VPH    = 5;
    localparam logic CHK_BP = 1'b1;
    localparam logic EXP_Q  = 1'b0;
`endif

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic        second;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sync;
    logic [3:0]  data;
    logic        rec_ready;
    logic [2:0]  phase;
    logic        locked;
    logic        rec_valid;
    logic [11:0] rec_addr;
    logic [3:0]  rec_opr;
    logic [3:0]  rec_opa;
    logic        rec_second;
    logic        desync;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    vec_t vecs [11];

    always #5 clock = ~clock;

    bus_cycle_monitor #(.FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .sync       (sync),
        .data       (data),
        .phase      (phase),
        .locked     (locked),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_addr   (rec_addr),
        .rec_opr    (rec_opr),
        .rec_opa    (rec_opa),
        .rec_second (rec_second),
        .desync     (desync),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] nib(input logic [11:0] a, input logic [3:0] o,
                                       input logic [3:0] v, input int p);
        case (p)
            0:       return a[3:0];
            1:       return a[7:4];
            2:       return a[11:8];
            3:       return o;
            4:       return v;
            default: return 4'hA;
        endcase
    endfunction

    // One full instruction cycle starting at A1; sync at X3 when do_sync
    task automatic run_cycle(input logic [11:0] a, input logic [3:0] o, input logic [3:0] v,
                             input logic exp_sec, input logic do_sync, input logic chk_rec);
        for (int p = 0; p < 8; p++) begin
            chk("phase", 32'(phase), 32'(p));
            chk("locked", 32'(locked), 32'd1);
            if (p > 0) chk("desync_idle", 32'(desync), 32'd0);
            if (chk_rec) begin
                chk("rec_valid", 32'(rec_valid), 32'(p == VPH));
                if (p == VPH) begin
                    chk("rec_addr", 32'(rec_addr), 32'(a));
                    chk("rec_opr", 32'(rec_opr), 32'(o));
                    chk("rec_opa", 32'(rec_opa), 32'(v));
                    chk("rec_second", 32'(rec_second), 32'(exp_sec));
                end
            end
            data = nib(a, o, v, p);
            sync = do_sync && (p == 7);
            step();
        end
        sync = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{12'h123, 4'hD, 4'h4, 1'b0};
        vecs[1]  = '{12'hABC, 4'h4, 4'h0, 1'b0};  // JUN
        vecs[2]  = '{12'h035, 4'h3, 4'h5, 1'b1};
        vecs[3]  = '{12'h456, 4'h1, 4'h0, 1'b0};  // JCN
        vecs[4]  = '{12'h789, 4'h2, 4'h2, 1'b1};  // FIM as second word: no chaining
        vecs[5]  = '{12'h111, 4'h2, 4'h3, 1'b0};  // SRC, one word
        vecs[6]  = '{12'h222, 4'h5, 4'h0, 1'b0};  // JMS
        vecs[7]  = '{12'h333, 4'h7, 4'h7, 1'b1};
        vecs[8]  = '{12'hFFF, 4'h7, 4'h1, 1'b0};  // ISZ
        vecs[9]  = '{12'h000, 4'h0, 4'h0, 1'b1};
        vecs[10] = '{12'h5A5, 4'hF, 4'hF, 1'b0};

        reset = 1'b1; sync = 1'b0; data = 4'h0; rec_ready = 1'b1;
        step();
        step();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_valid", 32'(rec_valid), 32'd0);
        chk("rst_desync", 32'(desync), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(rec_addr), 32'd0);
        chk("rst_second", 32'(rec_second), 32'd0);

        reset = 1'b0;
        step();
        step();
        chk("unsync_locked", 32'(locked), 32'd0);
        chk("unsync_phase", 32'(phase), 32'd0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_phase", 32'(phase), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_cycle(vecs[i].addr, vecs[i].opr, vecs[i].opa, vecs[i].second, 1'b1, 1'b1);
        end

        // sync in M1: abort, realign, flag cleared
        run_cycle(12'h864, 4'h4, 4'h0, 1'b0, 1'b1, 1'b1);
        for (int p = 0; p < 4; p++) begin
            chk("abort_phase", 32'(phase), 32'(p));
            chk("abort_valid", 32'(rec_valid), 32'd0);
            data = nib(12'h999, 4'h4, 4'h0, p);
            sync = (p == 3);
            step();
        end
        sync = 1'b0;
        chk("abort_desync", 32'(desync), 32'd1);
        chk("abort_phase_a1", 32'(phase), 32'd0);
        chk("abort_locked", 32'(locked), 32'd1);
        run_cycle(12'h468, 4'hA, 4'h1, 1'b0, 1'b1, 1'b1);

        // sync withheld at X3: drop lock, flag cleared
        run_cycle(12'h0F0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("miss_locked", 32'(locked), 32'd0);
        chk("miss_desync", 32'(desync), 32'd1);
        chk("miss_phase", 32'(phase), 32'd0);
        step();
        chk("miss_desync_end", 32'(desync), 32'd0);
        chk("miss_still_unsync", 32'(locked), 32'd0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("relock", 32'(locked), 32'd1);
        run_cycle(12'h321, 4'hC, 4'h3, 1'b0, 1'b1, 1'b1);

        // Backpressure: five fetches with rec_ready low
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle({4'(i + 1), 4'h0, 4'(i + 1)}, 4'h6, 4'(i), 1'b0, 1'b1, CHK_BP);
            if (i == 3) chk("ovf_before_drop", 32'(overflow), 32'd0);
        end
        chk("ovf_after_drop", 32'(overflow), 32'(EXP_Q));
`ifdef MONITOR_FIFO_EN
        chk("bp_valid", 32'(rec_valid), 32'd1);
        chk("bp_hold_addr", 32'(rec_addr), 32'h101);
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", 32'(rec_valid), 32'd1);
            chk("drain_addr", 32'(rec_addr), 32'({4'(k + 1), 4'h0, 4'(k + 1)}));
            data = 4'h0;
            step();
        end
        chk("drain_empty", 32'(rec_valid), 32'd0);
        for (int p = 4; p < 8; p++) begin
            data = 4'h0;
            sync = (p == 7);
            step();
        end
        sync = 1'b0;
`endif

        // Reset in M1 with two records pending
        rec_ready = 1'b0;
        run_cycle(12'h7E1, 4'h6, 4'h1, 1'b0, 1'b1, CHK_BP);
        run_cycle(12'h7E2, 4'h6, 4'h2, 1'b0, 1'b1, CHK_BP);
        for (int p = 0; p < 3; p++) begin
            data = nib(12'h7E3, 4'h6, 4'h3, p);
            step();
        end
        chk("pre_rst_phase", 32'(phase), 32'd3);
        chk("pre_rst_valid", 32'(rec_valid), 32'(EXP_Q));
        chk("pre_rst_ovf", 32'(overflow), 32'(EXP_Q));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(rec_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_addr", 32'(rec_addr), 32'd0);
        rec_ready = 1'b1;
        sync = 1'b1;
        step();
        sync = 1'b0;
        run_cycle(12'h9C9, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
